uart_rx_framed: RTL and testbench

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

---
 rtl/uart_rx_framed.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framed.sv
// UART receiver with majority-vote bit sampling, optional parity, 1/2 stop bits,
// break detection and a valid/ready output register with sticky overrun.
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 217,
  parameter int N_BITS       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [N_BITS-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy,
  output logic [2:0]        state_out
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(N_BITS) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_MID  = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0] T_S1   = TW'(CLKS_PER_BIT - 3);
  localparam logic [TW-1:0] T_S2   = TW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] I_DLAST = IW'(N_BITS - 1);
  localparam logic [IW-1:0] I_SLAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Odd parity inverts the reduction so a matching parity bit yields 0.
  function automatic logic parity_mismatch(input logic pbit, input logic [N_BITS-1:0] bits);
    return pbit ^ ((PARITY == 1) ? ^bits : ~^bits);
  endfunction

  logic              rx_meta_q, rx_sync_q, rx_s;
  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [1:0]        samp_q, samp_d;
  logic [N_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic              perr_q, perr_d, ferr_q, ferr_d;
  logic              valid_q, valid_d, parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d, overrun_q, overrun_d, busy_q, busy_d;
  logic              bit_now, decide, last_stop, handshake;

  assign rx_s = rx_sync_q;

  // Two-flop synchronizer, idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Next-state, bit-timing and output-register logic.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    data_d       = data_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    last_stop    = 1'b0;
    decide       = (timer_q == T_LAST);
    bit_now      = maj3(samp_q[1], samp_q[0], rx_s);
    handshake    = valid_q & ready;

    if (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP) begin
      timer_d = decide ? '0 : timer_q + 1'b1;
      if (timer_q == T_S1) samp_d[1] = rx_s;
      else if (timer_q == T_S2) samp_d[0] = rx_s;
      else samp_d = samp_q;
    end else begin
      samp_d = samp_q;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          timer_d = '0;
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (timer_q == T_MID) begin
          timer_d = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (decide) begin
          shift_d = {bit_now, shift_q[N_BITS-1:1]};
          if (idx_q == I_DLAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      S_PARITY: begin
        if (decide) begin
          perr_d  = parity_mismatch(bit_now, shift_q);
          state_d = S_STOP;
        end else begin
          perr_d = perr_q;
        end
      end
      S_STOP: begin
        if (decide) begin
          ferr_d = ferr_q | ~bit_now;
          if (idx_q == I_SLAST) begin
            last_stop = 1'b1;
            idx_d     = '0;
            state_d   = bit_now ? S_IDLE : S_BREAK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          ferr_d = ferr_q;
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
        else state_d = S_BREAK;
      end
      default: state_d = S_IDLE;
    endcase

    // A completed frame either loads the output register or is dropped.
    if (last_stop) begin
      if (!valid_q || ready) begin
        data_d       = shift_q;
        parity_err_d = (PARITY != 0) ? perr_q : 1'b0;
        frame_err_d  = ferr_q | ~bit_now;
        valid_d      = 1'b1;
        overrun_d    = handshake ? 1'b0 : overrun_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      idx_q        <= '0;
      samp_q       <= 2'b00;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: three instances cover no-parity/8N1,
// even parity, and odd parity with 5 data bits and 2 stop bits.
module tb_uart_rx_framed;

  logic clk = 1'b0;
  logic rst_n, rst2;
  logic rx0, rx1, rx2;
  logic ready0, ready1, ready2;

  logic [7:0] data0, data1;
  logic [4:0] data2;
  logic valid0, valid1, valid2, perr0, perr1, perr2, ferr0, ferr1, ferr2;
  logic ovr0, ovr1, ovr2, busy0, busy1, busy2;
  logic [2:0] st0, st1, st2;

  int checks = 0;
  int errors = 0;
  int hs0 = 0;
  int hs1 = 0;
  logic [7:0] hs_data0, hs_data1;
  logic hs_perr0, hs_ferr0, hs_perr1, hs_ferr1;

  always #5 clk = ~clk;

  uart_rx_framed #(.CLKS_PER_BIT(4), .N_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst_n), .rx(rx0), .data(data0), .valid(valid0), .ready(ready0),
    .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .busy(busy0), .state_out(st0));

  uart_rx_framed #(.CLKS_PER_BIT(4), .N_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst_n), .rx(rx1), .data(data1), .valid(valid1), .ready(ready1),
    .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .busy(busy1), .state_out(st1));

  uart_rx_framed #(.CLKS_PER_BIT(4), .N_BITS(5), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst2), .rx(rx2), .data(data2), .valid(valid2), .ready(ready2),
    .parity_err(perr2), .frame_err(ferr2), .overrun(ovr2), .busy(busy2), .state_out(st2));

  // Record every accepted word, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid0 && ready0) begin
      hs0      <= hs0 + 1;
      hs_data0 <= data0;
      hs_perr0 <= perr0;
      hs_ferr0 <= ferr0;
    end
    if (valid1 && ready1) begin
      hs1      <= hs1 + 1;
      hs_data1 <= data1;
      hs_perr1 <= perr1;
      hs_ferr1 <= ferr1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int line, input logic v);
    case (line)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Drive n line bits, LSB first, 4 clocks each.
  task automatic send_bits(input int line, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(line, bits[i]);
      tick(4);
    end
    set_rx(line, 1'b1);
  endtask

  initial begin
    int  hs_before;
    logic saw_start;
    rst_n = 1'b0; rst2 = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b0;
    tick(3);
    check_eq("rst_valid", 32'(valid0), 32'd0);
    check_eq("rst_data", 32'(data0), 32'd0);
    check_eq("rst_state", 32'(st0), 32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_overrun", 32'(ovr0), 32'd0);
    check_eq("rst_errs", 32'({perr0, ferr0}), 32'd0);
    rst_n = 1'b1; rst2 = 1'b1;
    tick(3);

    // 8N1 word 0xA5
    send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
    tick(12);
    check_eq("a5_count", 32'(hs0), 32'd1);
    check_eq("a5_data", 32'(hs_data0), 32'hA5);
    check_eq("a5_errs", 32'({hs_perr0, hs_ferr0}), 32'd0);
    check_eq("a5_valid_low", 32'(valid0), 32'd0);

    // one-clock glitch
    saw_start = 1'b0;
    rx0 = 1'b0; tick(1); rx0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (st0 == 3'd1) saw_start = 1'b1;
    end
    check_eq("glitch_start", 32'(saw_start), 32'd1);
    check_eq("glitch_idle", 32'(st0), 32'd0);
    check_eq("glitch_novalid", 32'(hs0), 32'd1);

    // overrun: second word dropped while first pending
    ready0 = 1'b0;
    send_bits(0, 16'({1'b1, 8'h11, 1'b0}), 10);
    tick(4);
    send_bits(0, 16'({1'b1, 8'h22, 1'b0}), 10);
    tick(12);
    check_eq("ovr_valid", 32'(valid0), 32'd1);
    check_eq("ovr_data", 32'(data0), 32'h11);
    check_eq("ovr_flag", 32'(ovr0), 32'd1);
    ready0 = 1'b1;
    tick(1);
    check_eq("ovr_hs_data", 32'(hs_data0), 32'h11);
    check_eq("ovr_hs_count", 32'(hs0), 32'd2);
    check_eq("ovr_cleared", 32'(ovr0), 32'd0);
    check_eq("ovr_valid_low", 32'(valid0), 32'd0);

    // low stop bit followed by a held-low line
    send_bits(0, 16'({1'b0, 8'h3C, 1'b0}), 10);
    rx0 = 1'b0;
    tick(30);
    check_eq("brk_state", 32'(st0), 32'd5);
    check_eq("brk_busy", 32'(busy0), 32'd1);
    check_eq("brk_count", 32'(hs0), 32'd3);
    check_eq("brk_data", 32'(hs_data0), 32'h3C);
    check_eq("brk_ferr", 32'(hs_ferr0), 32'd1);
    rx0 = 1'b1;
    tick(10);
    check_eq("brk_exit", 32'(st0), 32'd0);
    tick(30);
    check_eq("brk_single", 32'(hs0), 32'd3);

    // even parity
    send_bits(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
    tick(12);
    check_eq("even_ok_count", 32'(hs1), 32'd1);
    check_eq("even_ok_data", 32'(hs_data1), 32'h07);
    check_eq("even_ok_perr", 32'(hs_perr1), 32'd0);
    send_bits(1, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
    tick(12);
    check_eq("even_bad_count", 32'(hs1), 32'd2);
    check_eq("even_bad_data", 32'(hs_data1), 32'h07);
    check_eq("even_bad_perr", 32'(hs_perr1), 32'd1);
    check_eq("even_bad_ferr", 32'(hs_ferr1), 32'd0);

    // odd parity, 5 bits, 2 stop bits; word stays on output (ready2=0)
    send_bits(2, 16'({2'b11, 1'b0, 5'h1F, 1'b0}), 9);
    tick(12);
    check_eq("odd_valid", 32'(valid2), 32'd1);
    check_eq("odd_data", 32'(data2), 32'h1F);
    check_eq("odd_errs", 32'({perr2, ferr2}), 32'd0);

    // reset mid-frame
    rx2 = 1'b0;
    tick(6);
    check_eq("mid_busy", 32'(busy2), 32'd1);
    rst2 = 1'b0;
    #1;
    check_eq("arst_valid", 32'(valid2), 32'd0);
    check_eq("arst_data", 32'(data2), 32'd0);
    check_eq("arst_state", 32'(st2), 32'd0);
    check_eq("arst_busy", 32'(busy2), 32'd0);
    check_eq("arst_flags", 32'({perr2, ferr2, ovr2}), 32'd0);
    rx2 = 1'b1;
    tick(2);
    rst2 = 1'b1;
    tick(60);
    check_eq("abort_novalid", 32'(valid2), 32'd0);
    send_bits(2, 16'({2'b11, 1'b1, 5'h0A, 1'b0}), 9);
    tick(12);
    check_eq("resume_valid", 32'(valid2), 32'd1);
    check_eq("resume_data", 32'(data2), 32'h0A);
    check_eq("resume_perr", 32'(perr2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
